turret_sprite_fetch: RTL and testbench
======================================

TURRET_SPRITE_FETCH -- requirements
Module: turret_sprite_fetch

Interface
REQ-001 SHALL have parameter SPRITE_W, default 32: sprite width in pixels, a power of two.
REQ-002 SHALL have parameter SPRITE_H, default 32: sprite height in pixels, a power of two.
REQ-003 SHALL have parameter ROT_FRAMES, default 4: frames per one-step turret rotation, range 1..255.
REQ-004 SHALL have parameter TRANSPARENT_IDX, default 8'h00: colour key that is never drawn.
REQ-005 SHALL have port Clk  input  1  the single clock. Reset is synchronous and active-high.
REQ-006 SHALL have port Reset  input  1  synchronous active-high reset.
REQ-007 SHALL have port frame_start  input  1  one-cycle pulse at the start of vertical blank.
REQ-008 SHALL have port DrawX  input  10  current pixel column.
REQ-009 SHALL have port DrawY  input  10  current pixel row.
REQ-010 SHALL have port turret_x  input  10  sprite top-left column.
REQ-011 SHALL have port turret_y  input  10  sprite top-left row.
REQ-012 SHALL have port dir_target  input  3  requested orientation, 0..7, in 45-degree steps, clockwise.
REQ-013 SHALL have port rom_addr  output  13  sprite ROM address {dir, row, col}.
REQ-014 SHALL have port rom_q  input  8  ROM data; the ROM is synchronous with 1-cycle read latency.
REQ-015 SHALL have port pix_index  output  8  palette index, fed directly to the palette lookup.
REQ-016 SHALL have port pix_valid  output  1  the turret pixel is opaque at this position.
REQ-017 SHALL have port dir_cur  output  3  orientation currently being drawn.

Function
REQ-018 SHALL capture turret_x and turret_y into shadow registers only on frame_start, so a frame never tears.
REQ-019 SHALL compute the hit test using the shadow position: hit = (DrawX-x) < SPRITE_W and (DrawY-y) < SPRITE_H, using 11-bit unsigned subtraction. Negative differences are treated as misses, and there is no wrap at column or row 1023.
REQ-020 SHALL register rom_addr at t+1 as {dir_cur, DrawY-y, DrawX-x}, truncated to the low bits. On a miss, rom_addr is 0.
REQ-021 SHALL register pix_index and pix_valid at t+3 for DrawX/DrawY presented at t, with a fixed latency of 3.
REQ-022 SHALL set pix_valid = delayed hit AND rom_q != TRANSPARENT_IDX.
REQ-023 SHALL output pix_index = rom_q when pix_valid is set, and 8'h00 otherwise.
REQ-024 SHALL run a rotation FSM with states IDLE and ROTATE. IDLE goes to ROTATE when dir_target != dir_cur, and the frame counter is cleared on that transition.
REQ-025 In ROTATE, the FSM SHALL increment the frame counter on each frame_start. When the counter reaches ROT_FRAMES-1 on a frame_start:
- dir_cur steps one position toward dir_target by the shortest path, modulo 8;
- the counter clears;
- the FSM returns to IDLE if dir_cur now equals dir_target.
REQ-026 SHALL break the shortest-path tie (difference = 4) clockwise, i.e. +1.
REQ-027 SHALL change dir_cur only on frame_start, so it is stable across a whole frame.
REQ-028 If dir_target changes mid-rotation, the FSM SHALL aim at the new target from the next step onward without clearing the counter. If the new target equals dir_cur, the FSM SHALL return to IDLE.
REQ-029 SHALL let a frame_start coincident with a hit pixel update the shadow registers for the next cycle only; pixels already in the pipeline complete with their old values.

Reset
REQ-030 On Reset, all outputs (rom_addr, pix_index, pix_valid, dir_cur) SHALL be 0 on the next edge, along with the shadow registers, frame counter and pipeline hit flags, and the FSM SHALL enter IDLE.
REQ-031 Reset asserted mid-rotation or mid-pipeline SHALL discard in-flight pixels; pix_valid SHALL stay 0 until 3 cycles after the first post-reset hit.

Structure
REQ-032 turret_pkg SHALL hold dir_t (3-bit), the SPRITE_W/SPRITE_H defaults, TRANSPARENT_IDX, and the FSM state enum.
REQ-033 The rotation FSM and frame counter SHALL be a sub-module named turret_rot_fsm. The hit test and pipeline stay in the top level.

Verification
REQ-034 Bench SHALL cover: shadow x=100, y=50, dir 0; DrawX=100, DrawY=50 at t with the ROM model returning 8'h2A -> rom_addr=13'h0000 at t+1, pix_valid=1 and pix_index=8'h2A at t+3.
REQ-035 Bench SHALL cover: same position, DrawX=131, DrawY=81 -> rom_addr=13'h03FF. DrawX=132 -> miss, pix_valid=0, pix_index=0.
REQ-036 Bench SHALL cover: x=1000 with DrawX=5 -> miss, with no wrap-around hit. A hit pixel whose ROM data is 8'h00 -> pix_valid=0.
REQ-037 Bench SHALL cover: dir_cur=0, dir_target=3, ROT_FRAMES=4 -> dir_cur becomes 1, 2 and 3 on the 4th, 8th and 12th frame_start; the FSM is then IDLE.
REQ-038 Bench SHALL cover: dir_cur=6, dir_target=2 (tie) -> steps 7, 0, 1, 2. dir_cur=1, dir_target=7 -> steps 0, 7.
REQ-039 Bench SHALL cover: turret_x changed mid-frame -> no change to hit columns until after the next frame_start. Reset in ROTATE -> dir_cur=0, IDLE, pix_valid=0.

Source files
------------

// File: rtl/turret_pkg.sv
// Shared types and defaults for the turret sprite fetch path: orientation type,
// sprite geometry defaults, colour key and the rotation state encoding.
package turret_pkg;

   typedef logic [2:0] dir_t;

   localparam int unsigned SPRITE_W_DEF        = 32;
   localparam int unsigned SPRITE_H_DEF        = 32;
   localparam logic [7:0]  TRANSPARENT_IDX_DEF = 8'h00;

   typedef enum logic {
      ST_IDLE,
      ST_ROTATE
   } rot_state_t;

   // One 45-degree step toward tgt by the shortest path; a half-turn goes clockwise.
   function automatic dir_t step_toward(input dir_t cur, input dir_t tgt);
      dir_t diff;
      diff = tgt - cur;
      if (diff == 3'd0)
         return cur;
      else if (diff <= 3'd4)
         return cur + 3'd1;
      else
         return cur - 3'd1;
   endfunction

endpackage

// File: rtl/turret_rot_fsm.sv
// Turret rotation sequencer: walks dir_cur toward dir_target one step every
// ROT_FRAMES frames, changing orientation only on frame_start.
module turret_rot_fsm
   import turret_pkg::*;
#(
   parameter int unsigned ROT_FRAMES = 4
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic frame_start_i,
   input  dir_t dir_target_i,
   output dir_t dir_cur_o
);

   localparam logic [7:0] LAST_FRAME = 8'(ROT_FRAMES - 1);

   rot_state_t state_q;
   logic [7:0] cnt_q;
   dir_t       dir_q;
   dir_t       dir_step_d;

   always_comb begin
      dir_step_d = step_toward(dir_q, dir_target_i);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         dir_q   <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (dir_target_i != dir_q) begin
                  state_q <= ST_ROTATE;
                  cnt_q   <= '0;
               end
            end
            ST_ROTATE: begin
               // A retarget onto the current orientation ends the rotation at once.
               if (dir_target_i == dir_q) begin
                  state_q <= ST_IDLE;
               end else if (frame_start_i) begin
                  if (cnt_q == LAST_FRAME) begin
                     dir_q <= dir_step_d;
                     cnt_q <= '0;
                     if (dir_step_d == dir_target_i)
                        state_q <= ST_IDLE;
                  end else begin
                     cnt_q <= cnt_q + 8'd1;
                  end
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign dir_cur_o = dir_q;

endmodule

// File: rtl/turret_sprite_fetch.sv
// Turret sprite fetch: frame-latched position, hit test, ROM address generation
// and a fixed 3-cycle pixel pipeline around a 1-cycle synchronous sprite ROM.
module turret_sprite_fetch
   import turret_pkg::*;
#(
   parameter int unsigned SPRITE_W        = SPRITE_W_DEF,
   parameter int unsigned SPRITE_H        = SPRITE_H_DEF,
   parameter int unsigned ROT_FRAMES      = 4,
   parameter logic [7:0]  TRANSPARENT_IDX = TRANSPARENT_IDX_DEF
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        frame_start,
   input  logic [9:0]  DrawX,
   input  logic [9:0]  DrawY,
   input  logic [9:0]  turret_x,
   input  logic [9:0]  turret_y,
   input  logic [2:0]  dir_target,
   output logic [12:0] rom_addr,
   input  logic [7:0]  rom_q,
   output logic [7:0]  pix_index,
   output logic        pix_valid,
   output logic [2:0]  dir_cur
);

   localparam int unsigned XW = $clog2(SPRITE_W);
   localparam int unsigned YW = $clog2(SPRITE_H);

   logic [9:0]  x_q, y_q;
   logic [10:0] dx_d, dy_d;
   logic        hit_d;
   logic [12:0] addr_d;
   logic [12:0] rom_addr_q;
   logic        hit1_q, hit2_q;
   logic        opaque_d;
   logic        pix_valid_q;
   logic [7:0]  pix_index_q;
   dir_t        dir_cur_w;

   turret_rot_fsm #(
      .ROT_FRAMES (ROT_FRAMES)
   ) u_rot (
      .clk_i         (Clk),
      .rst_i         (Reset),
      .frame_start_i (frame_start),
      .dir_target_i  (dir_target),
      .dir_cur_o     (dir_cur_w)
   );

   // 11-bit differences: a pixel left of / above the sprite sets bit 10 and misses.
   always_comb begin
      dx_d   = {1'b0, DrawX} - {1'b0, x_q};
      dy_d   = {1'b0, DrawY} - {1'b0, y_q};
      hit_d  = (dx_d < 11'(SPRITE_W)) && (dy_d < 11'(SPRITE_H));
      addr_d = '0;
      if (hit_d)
         addr_d = 13'({dir_cur_w, dy_d[YW-1:0], dx_d[XW-1:0]});
   end

   always_comb begin
      opaque_d = hit2_q && (rom_q != TRANSPARENT_IDX);
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         x_q         <= '0;
         y_q         <= '0;
         rom_addr_q  <= '0;
         hit1_q      <= 1'b0;
         hit2_q      <= 1'b0;
         pix_valid_q <= 1'b0;
         pix_index_q <= '0;
      end else begin
         if (frame_start) begin
            x_q <= turret_x;
            y_q <= turret_y;
         end
         rom_addr_q  <= addr_d;
         hit1_q      <= hit_d;
         hit2_q      <= hit1_q;
         pix_valid_q <= opaque_d;
         pix_index_q <= opaque_d ? rom_q : 8'h00;
      end
   end

   assign rom_addr  = rom_addr_q;
   assign pix_valid = pix_valid_q;
   assign pix_index = pix_index_q;
   assign dir_cur   = dir_cur_w;

endmodule

// File: tb/tb_turret_sprite_fetch.sv
// Directed bench for turret_sprite_fetch; the ROM model returns addr[7:0] ^ 8'h2A
// one cycle after the address, so addr 0 reads 8'h2A and addr 13'h02A reads 8'h00.
module tb_turret_sprite_fetch;
   import turret_pkg::*;

   logic        Clk = 1'b0;
   logic        Reset;
   logic        frame_start;
   logic [9:0]  DrawX, DrawY, turret_x, turret_y;
   logic [2:0]  dir_target;
   logic [12:0] rom_addr;
   logic [7:0]  rom_q;
   logic [7:0]  pix_index;
   logic        pix_valid;
   logic [2:0]  dir_cur;

   int n_checks = 0;
   int n_errors = 0;

   always #5 Clk = ~Clk;

   always @(posedge Clk) rom_q <= rom_addr[7:0] ^ 8'h2A;

   turret_sprite_fetch #(
      .SPRITE_W        (32),
      .SPRITE_H        (32),
      .ROT_FRAMES      (4),
      .TRANSPARENT_IDX (8'h00)
   ) dut (
      .Clk         (Clk),
      .Reset       (Reset),
      .frame_start (frame_start),
      .DrawX       (DrawX),
      .DrawY       (DrawY),
      .turret_x    (turret_x),
      .turret_y    (turret_y),
      .dir_target  (dir_target),
      .rom_addr    (rom_addr),
      .rom_q       (rom_q),
      .pix_index   (pix_index),
      .pix_valid   (pix_valid),
      .dir_cur     (dir_cur)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic frame_pulse();
      @(negedge Clk) frame_start = 1'b1;
      @(negedge Clk) frame_start = 1'b0;
   endtask

   task automatic place(input logic [9:0] x, input logic [9:0] y);
      @(negedge Clk);
      turret_x = x;
      turret_y = y;
      frame_pulse();
   endtask

   task automatic pixel(input string tag, input logic [9:0] x, input logic [9:0] y,
                        input logic [12:0] ea, input logic ev, input logic [7:0] ei);
      @(negedge Clk);
      DrawX = x;
      DrawY = y;
      @(posedge Clk); #1;
      check({tag, ".addr"}, 32'(rom_addr), 32'(ea));
      @(posedge Clk);
      @(posedge Clk); #1;
      check({tag, ".valid"}, 32'(pix_valid), 32'(ev));
      check({tag, ".index"}, 32'(pix_index), 32'(ei));
   endtask

   task automatic set_target(input logic [2:0] t);
      @(negedge Clk) dir_target = t;
      @(negedge Clk);
   endtask

   // Three frames must leave the orientation alone; the fourth takes the step.
   task automatic step(input string tag, input logic [2:0] prev, input logic [2:0] exp);
      repeat (3) frame_pulse();
      check({tag, ".hold"}, 32'(dir_cur), 32'(prev));
      frame_pulse();
      check({tag, ".step"}, 32'(dir_cur), 32'(exp));
   endtask

   task automatic check_idle(input string tag);
      check(tag, 32'(dut.u_rot.state_q), 32'(ST_IDLE));
   endtask

   initial begin
      Reset       = 1'b1;
      frame_start = 1'b0;
      DrawX       = '0;
      DrawY       = '0;
      turret_x    = '0;
      turret_y    = '0;
      dir_target  = '0;
      repeat (2) @(posedge Clk);
      #1;
      check("rst.addr", 32'(rom_addr), 32'h0);
      check("rst.valid", 32'(pix_valid), 32'h0);
      check("rst.index", 32'(pix_index), 32'h0);
      check("rst.dir", 32'(dir_cur), 32'h0);
      check_idle("rst.state");
      @(negedge Clk) Reset = 1'b0;

      place(10'd100, 10'd50);
      pixel("origin", 10'd100, 10'd50, 13'h0000, 1'b1, 8'h2A);
      pixel("corner", 10'd131, 10'd81, 13'h03FF, 1'b1, 8'hD5);
      pixel("right_miss", 10'd132, 10'd81, 13'h0000, 1'b0, 8'h00);
      pixel("left_miss", 10'd99, 10'd50, 13'h0000, 1'b0, 8'h00);
      pixel("transparent", 10'd110, 10'd51, 13'h002A, 1'b0, 8'h00);

      place(10'd1000, 10'd50);
      pixel("nowrap", 10'd5, 10'd50, 13'h0000, 1'b0, 8'h00);
      pixel("edge1023", 10'd1023, 10'd50, 13'h0017, 1'b1, 8'h3D);

      place(10'd100, 10'd50);
      set_target(3'd3);
      step("r03a", 3'd0, 3'd1);
      step("r03b", 3'd1, 3'd2);
      step("r03c", 3'd2, 3'd3);
      check_idle("r03.idle");

      set_target(3'd6);
      step("r36a", 3'd3, 3'd4);
      step("r36b", 3'd4, 3'd5);
      step("r36c", 3'd5, 3'd6);
      set_target(3'd2);
      step("tie_a", 3'd6, 3'd7);
      step("tie_b", 3'd7, 3'd0);
      step("tie_c", 3'd0, 3'd1);
      step("tie_d", 3'd1, 3'd2);
      check_idle("tie.idle");
      set_target(3'd1);
      step("r21", 3'd2, 3'd1);
      set_target(3'd7);
      step("r17a", 3'd1, 3'd0);
      step("r17b", 3'd0, 3'd7);
      check_idle("r17.idle");

      @(negedge Clk) turret_x = 10'd200;
      pixel("tear_old", 10'd100, 10'd50, 13'h1C00, 1'b1, 8'h2A);
      pixel("tear_new_miss", 10'd200, 10'd50, 13'h0000, 1'b0, 8'h00);
      frame_pulse();
      pixel("moved_old_miss", 10'd100, 10'd50, 13'h0000, 1'b0, 8'h00);
      pixel("moved_new", 10'd200, 10'd50, 13'h1C00, 1'b1, 8'h2A);

      set_target(3'd3);
      repeat (2) frame_pulse();
      @(negedge Clk);
      DrawX = 10'd200;
      DrawY = 10'd50;
      @(negedge Clk) Reset = 1'b1;
      @(posedge Clk); #1;
      check("rrst.dir", 32'(dir_cur), 32'h0);
      check_idle("rrst.state");
      check("rrst.valid", 32'(pix_valid), 32'h0);
      check("rrst.addr", 32'(rom_addr), 32'h0);
      @(negedge Clk) Reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge Clk); #1;
         check("rrst.flush", 32'(pix_valid), 32'h0);
      end
      place(10'd200, 10'd50);
      pixel("post_rst", 10'd200, 10'd50, 13'h0000, 1'b1, 8'h2A);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
